// File: rtl/mem_loader.sv
// Boot loader: takes a length-prefixed, big-endian byte stream and writes it as 32-bit words into CPU memory.
// Holds the CPU in reset until a load completes; each word takes 4 accept cycles plus 1 write cycle.
`timescale 1ns/1ps
module mem_loader #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset_n,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERR} state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t      state;
  logic [7:0]  len_hi;
  logic [15:0] word_total;
  logic [15:0] word_cnt;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_word;

  logic        accept;
  logic [15:0] len_word;
  logic [15:0] word_cnt_nxt;

  assign accept       = in_valid && in_ready;
  assign len_word     = {len_hi, in_data};
  assign word_cnt_nxt = word_cnt + 16'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      len_hi      <= 8'd0;
      word_total  <= 16'd0;
      word_cnt    <= 16'd0;
      byte_cnt    <= 2'd0;
      asm_word    <= 24'd0;
      in_ready    <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      cpu_reset_n <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state       <= LEN;
            in_ready    <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
            cpu_reset_n <= 1'b0;
            byte_cnt    <= 2'd0;
            word_cnt    <= 16'd0;
          end
        end

        LEN: begin
          if (accept) begin
            if (byte_cnt == 2'd0) begin
              len_hi   <= in_data;
              byte_cnt <= 2'd1;
            end else begin
              byte_cnt   <= 2'd0;
              word_total <= len_word;
              if (len_word == 16'd0) begin
                state       <= DONE;
                in_ready    <= 1'b0;
                done        <= 1'b1;
                cpu_reset_n <= 1'b1;
              end else if ({16'd0, len_word} > DEPTH_W) begin
                state    <= ERR;
                in_ready <= 1'b0;
                error    <= 1'b1;
              end else begin
                state <= DATA;
              end
            end
          end
        end

        DATA: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              // Fourth byte goes straight into the write word; the shift register only holds the first three.
              state     <= WRITE;
              in_ready  <= 1'b0;
              mem_we    <= 1'b1;
              mem_wdata <= {asm_word, in_data};
              mem_addr  <= BASE_ADDR + {14'd0, word_cnt, 2'b00};
            end else begin
              asm_word <= {asm_word[15:0], in_data};
            end
          end
        end

        WRITE: begin
          word_cnt <= word_cnt_nxt;
          if (word_cnt_nxt == word_total) begin
            state       <= DONE;
            done        <= 1'b1;
            cpu_reset_n <= 1'b1;
          end else begin
            state    <= DATA;
            in_ready <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

  a_we_single: assert property (@(posedge clk) disable iff (!reset_n) mem_we |=> !mem_we);
  a_no_ready_in_write: assert property (@(posedge clk) disable iff (!reset_n) !(mem_we && in_ready));
  a_done_err_excl: assert property (@(posedge clk) disable iff (!reset_n) !(done && error));

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: two instances (default and DEPTH=4/BASE_ADDR=0x1000) selected by sel.
`timescale 1ns/1ps
module tb_mem_loader;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       start    = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'd0;
  logic       sel      = 1'b0;

  always #5 clk = ~clk;

  logic        rdy_a, we_a, crst_a, done_a, err_a;
  logic [31:0] addr_a, wd_a;
  logic        rdy_b, we_b, crst_b, done_b, err_b;
  logic [31:0] addr_b, wd_b;

  mem_loader dut_a (
    .clk(clk), .reset_n(reset_n), .start(start & ~sel), .in_valid(in_valid & ~sel),
    .in_data(in_data), .in_ready(rdy_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a),
    .cpu_reset_n(crst_a), .done(done_a), .error(err_a)
  );

  mem_loader #(.DEPTH(4), .BASE_ADDR(32'h0000_1000)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start & sel), .in_valid(in_valid & sel),
    .in_data(in_data), .in_ready(rdy_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b),
    .cpu_reset_n(crst_b), .done(done_b), .error(err_b)
  );

  logic        rdy, we, crst, dn, er;
  logic [31:0] addr, wd;
  assign rdy  = sel ? rdy_b  : rdy_a;
  assign we   = sel ? we_b   : we_a;
  assign crst = sel ? crst_b : crst_a;
  assign dn   = sel ? done_b : done_a;
  assign er   = sel ? err_b  : err_a;
  assign addr = sel ? addr_b : addr_a;
  assign wd   = sel ? wd_b   : wd_a;

  int tests = 0;
  int fails = 0;
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [7:0]  stream[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every write cycle is logged; a stuck mem_we shows up as extra entries.
  always @(negedge clk) begin
    if (we) begin
      wq_addr.push_back(addr);
      wq_data.push_back(wd);
      check("ready_low_in_write", 32'(rdy), 32'd0);
    end
  end

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},    32'(rdy),  32'd0);
    check({tag, "_mem_we"},      32'(we),   32'd0);
    check({tag, "_mem_addr"},    addr,      32'd0);
    check({tag, "_mem_wdata"},   wd,        32'd0);
    check({tag, "_cpu_reset_n"}, 32'(crst), 32'd0);
    check({tag, "_done"},        32'(dn),   32'd0);
    check({tag, "_error"},       32'(er),   32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    while (!rdy && n < 50) begin @(posedge clk); #1; n++; end
    if (!rdy) check("ready_timeout", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_all(input int gap);
    foreach (stream[i]) send_byte(stream[i], gap);
  endtask

  task automatic check_write(input string tag, input int idx, input logic [31:0] ea, input logic [31:0] ed);
    if (wq_addr.size() > idx) begin
      check({tag, "_addr"}, wq_addr[idx], ea);
      check({tag, "_data"}, wq_data[idx], ed);
    end else begin
      check({tag, "_missing"}, 32'(wq_addr.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check_reset_outputs("por");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", 32'(rdy), 32'd0);

    // Two-word back-to-back load at default base
    clear_log();
    pulse_start();
    stream = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    send_all(0);
    check("t1_done_before_write_end", 32'(dn), 32'd0);
    @(posedge clk); #1;
    check("t1_nwrites", 32'(wq_addr.size()), 32'd2);
    check_write("t1_w0", 0, 32'h0, 32'hDEADBEEF);
    check_write("t1_w1", 1, 32'h4, 32'h01234567);
    check("t1_done", 32'(dn), 32'd1);
    check("t1_cpu_reset_n", 32'(crst), 32'd1);
    check("t1_ready", 32'(rdy), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) begin @(posedge clk); #1; end
    check("t1_done_ignores_bytes", 32'(rdy), 32'd0);
    check("t1_done_sticky", 32'(dn), 32'd1);
    in_valid = 1'b0;

    // Reload from DONE with a zero-length image
    clear_log();
    pulse_start();
    check("t2_reload_cpu_reset_n", 32'(crst), 32'd0);
    check("t2_reload_done_clr", 32'(dn), 32'd0);
    check("t2_reload_ready", 32'(rdy), 32'd1);
    stream = '{8'h00, 8'h00};
    send_all(0);
    check("t2_done", 32'(dn), 32'd1);
    check("t2_cpu_reset_n", 32'(crst), 32'd1);
    @(posedge clk); #1;
    check("t2_nwrites", 32'(wq_addr.size()), 32'd0);

    // start held high through the second half of a word must be ignored
    clear_log();
    pulse_start();
    stream = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    send_all(0);
    start = 1'b1;
    stream = '{8'hCC, 8'hDD};
    send_all(0);
    start = 1'b0;
    @(posedge clk); #1;
    check("t4_nwrites", 32'(wq_addr.size()), 32'd1);
    check_write("t4_w0", 0, 32'h0, 32'hAABBCCDD);
    check("t4_done", 32'(dn), 32'd1);

    // DEPTH=4 instance: length 5 overflows
    sel = 1'b1;
    clear_log();
    pulse_start();
    stream = '{8'h00, 8'h05};
    send_all(0);
    check("t3_error", 32'(er), 32'd1);
    check("t3_cpu_reset_n", 32'(crst), 32'd0);
    check("t3_ready", 32'(rdy), 32'd0);
    check("t3_done", 32'(dn), 32'd0);
    in_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("t3_err_ignores_bytes", 32'(rdy), 32'd0);
    check("t3_error_sticky", 32'(er), 32'd1);
    in_valid = 1'b0;
    pulse_start();
    check("t3_error_cleared", 32'(er), 32'd0);
    check("t3_ready_after_start", 32'(rdy), 32'd1);
    check("t3_nwrites", 32'(wq_addr.size()), 32'd0);

    // Three words with in_valid toggling every cycle, base 0x1000
    stream = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
               8'h99, 8'hAA, 8'hBB, 8'hCC};
    send_all(1);
    @(posedge clk); #1;
    check("t6_nwrites", 32'(wq_addr.size()), 32'd3);
    check_write("t6_w0", 0, 32'h1000, 32'h11223344);
    check_write("t6_w1", 1, 32'h1004, 32'h55667788);
    check_write("t6_w2", 2, 32'h1008, 32'h99AABBCC);
    check("t6_done", 32'(dn), 32'd1);

    // N == DEPTH is legal; last write lands at BASE_ADDR + 4*(DEPTH-1)
    clear_log();
    pulse_start();
    stream = '{8'h00, 8'h04};
    for (int i = 0; i < 16; i++) stream.push_back(8'(i));
    send_all(0);
    @(posedge clk); #1;
    check("t7_nwrites", 32'(wq_addr.size()), 32'd4);
    check_write("t7_w3", 3, 32'h100C, 32'h0C0D0E0F);
    check("t7_done", 32'(dn), 32'd1);
    check("t7_error", 32'(er), 32'd0);

    // Reset in the middle of word 1 aborts immediately
    sel = 1'b0;
    clear_log();
    pulse_start();
    stream = '{8'h00, 8'h01, 8'hDE, 8'hAD};
    send_all(0);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t5_rst");
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("t5_nwrites_after_abort", 32'(wq_addr.size()), 32'd0);
    check("t5_idle_ready", 32'(rdy), 32'd0);
    check("t5_idle_cpu_reset_n", 32'(crst), 32'd0);
    pulse_start();
    stream = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    send_all(0);
    @(posedge clk); #1;
    check("t5_nwrites", 32'(wq_addr.size()), 32'd1);
    check_write("t5_w0", 0, 32'h0, 32'hCAFEBABE);
    check("t5_done", 32'(dn), 32'd1);
    check("t5_cpu_reset_n", 32'(crst), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, capacity of the target memory in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first word written.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle pulse that begins a load.
REQ-006 SHALL have port in_valid, input, 1, a byte is offered on in_data.
REQ-007 SHALL have port in_data, input, 8, stream byte.
REQ-008 SHALL have port in_ready, output, 1, loader accepts the byte this cycle.
REQ-009 SHALL have port mem_we, output, 1, write strobe to the CPU data/instruction memory.
REQ-010 SHALL have port mem_addr, output, 32, byte address of the write.
REQ-011 SHALL have port mem_wdata, output, 32, word written.
REQ-012 SHALL have port cpu_reset_n, output, 1, holds the CPU in reset while low.
REQ-013 SHALL have port done, output, 1, load completed successfully (sticky).
REQ-014 SHALL have port error, output, 1, load aborted on a length overflow (sticky).

Function
REQ-015 SHALL accept a byte only on a cycle where in_valid and in_ready are both 1.
REQ-016 SHALL implement states IDLE, LEN, DATA, WRITE, DONE, ERR.
REQ-017 IDLE: in_ready=0; start=1 -> LEN; clear done, error, byte and word counters; cpu_reset_n=0.
REQ-018 LEN: in_ready=1; accept 2 bytes forming a 16-bit word count N, first byte the MSB.
REQ-019 After the second LEN byte: N=0 -> DONE; N>DEPTH -> ERR; otherwise -> DATA.
REQ-020 DATA: in_ready=1; accept 4 bytes big-endian (first byte is bits 31:24) into an assembly register.
REQ-021 After the 4th byte SHALL go to WRITE next cycle.
REQ-022 WRITE lasts exactly 1 cycle: mem_we=1, in_ready=0, mem_wdata=assembled word, mem_addr=BASE_ADDR+4*k for the k-th word (k from 0).
REQ-023 After WRITE, k SHALL increment; k==N -> DONE, else -> DATA.
REQ-024 Minimum per-word latency SHALL be 5 cycles (4 accept cycles + 1 WRITE cycle).
REQ-025 mem_we SHALL be 0 in every state except WRITE; mem_addr/mem_wdata are don't-care when mem_we=0 but SHALL be registered (glitch-free).
REQ-026 DONE: done=1, cpu_reset_n=1, in_ready=0; start=1 -> LEN (reload: done, cpu_reset_n drop to 0 next cycle).
REQ-027 ERR: error=1, cpu_reset_n=0, in_ready=0; exits only on start=1 -> LEN with error cleared.
REQ-028 start SHALL be ignored in LEN, DATA and WRITE.
REQ-029 in_valid=0 mid-word SHALL stall without losing the bytes already assembled; no timeout.
REQ-030 Bytes presented in IDLE, DONE or ERR SHALL NOT be consumed.
REQ-031 Address arithmetic SHALL be 32-bit modulo 2^32; the word counter SHALL be 16 bits wide.
REQ-032 N==DEPTH SHALL be legal; the last write goes to BASE_ADDR+4*(DEPTH-1).

Reset
REQ-033 reset_n=0 SHALL immediately force IDLE, with in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset_n=0, done=0 and error=0.
REQ-034 Reset asserted mid-load SHALL abort the load; no further mem_we pulses until a new start is given.
REQ-035 Reset release SHALL take effect synchronously at the first clk edge after reset_n rises.

Verification
REQ-036 start, then bytes 00 02 DE AD BE EF 01 23 45 67 sent back-to-back -> writes DEADBEEF@0x0 and 01234567@0x4, each mem_we 1 cycle; done=1 and cpu_reset_n=1 after the 2nd write.
REQ-037 start, then bytes 00 00 -> DONE with no mem_we pulse; done=1.
REQ-038 DEPTH=4, length bytes 00 05 -> error=1, cpu_reset_n=0, in_ready=0, no writes; a new start then clears error.
REQ-039 in_valid toggled 0/1 every cycle during a 3-word load, BASE_ADDR=0x1000 -> data correct at 0x1000/0x1004/0x1008; in_ready=0 in every WRITE cycle.
REQ-040 reset_n pulsed low after 2 bytes of word 1 -> all outputs return to their reset values at once; a fresh start and full stream then load correctly from BASE_ADDR.
REQ-041 start held high during DATA -> ignored; pulsed in DONE -> cpu_reset_n=0 next cycle and a reload proceeds.
